// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    logic [0:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d, a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [1:0]  op_q, op_d;
    logic        done_q, done_d;
    logic        is_signed, div_zero;
    logic [63:0] mul_s, mul_u, res;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
    assign is_signed = ~op_q[0];
    assign mul_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign mul_u = {32'b0, a_q} * {32'b0, b_q};
    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 naturally.
    assign a_mag = (is_signed && a_q[31]) ? -a_q : a_q;
    assign b_mag = (is_signed && b_q[31]) ? -b_q : b_q;
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign quo = (is_signed && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
    assign rem = (is_signed && a_q[31]) ? -r_mag : r_mag;
    assign res = op_q[1] ? {rem, quo} : (op_q[0] ? mul_u : mul_s);
    assign div_zero = op_q[1] && (b_q == 32'b0);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (state_q == S_IDLE) begin
            if (start && !op[2]) begin
                state_d = S_RUN;
                cnt_d   = op[1] ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
                a_d     = A;
                b_d     = B;
                op_d    = op[1:0];
            end
            hi_d = (start && op == 3'b100) ? A : hi_q;
            lo_d = (start && op == 3'b101) ? A : lo_q;
        end else begin
            cnt_d = cnt_q - 32'd1;
            if (cnt_q == 32'd1) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                hi_d    = div_zero ? hi_q : res[63:32];
                lo_d    = div_zero ? lo_q : res[31:0];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end
    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized checks of md_unit against an arithmetic reference model.
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] HI, LO;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hi = 32'b0;
    logic [31:0] exp_lo = 32'b0;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint q, r;
        case (o)
            3'd0: {exp_hi, exp_lo} = sa * sb;
            3'd1: {exp_hi, exp_lo} = ua * ub;
            3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
            3'd3: if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where busy has dropped.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int bc, output int early_done);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom; op = 3'($urandom);
        bc = 0; early_done = 0;
        while (busy && bc < 200) begin
            bc++;
            if (done) early_done++;
            @(negedge clk);
        end
    endtask

    task automatic do_single(input logic [2:0] o, input logic [31:0] a);
        start = 1'b1; op = o; A = a; B = $urandom;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; op = 3'b100; A = 32'hFFFFFFFF; B = 32'h1;
        repeat (3) @(negedge clk);
        reset = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 00000000", HI); end
        checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 00000000", LO); end
    endtask

    task automatic test_mult;
        int bc, ed;
        do_op(3'd0, 32'hFFFFFFFF, 32'h2, bc, ed); model(3'd0, 32'hFFFFFFFF, 32'h2);
        checks++; if (bc !== MC) begin errors++; $display("FAIL mult_busy_cycles got %0d exp %0d", bc, MC); end
        checks++; if (ed !== 0) begin errors++; $display("FAIL mult_early_done got %0d exp 0", ed); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL mult_done got %b exp 1", done); end
        checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", HI); end
        checks++; if (LO !== 32'hFFFFFFFE) begin errors++; $display("FAIL mult_lo got %h exp fffffffe", LO); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b exp 0", done); end
        do_op(3'd1, 32'hFFFFFFFF, 32'h2, bc, ed); model(3'd1, 32'hFFFFFFFF, 32'h2);
        checks++; if (HI !== 32'h1) begin errors++; $display("FAIL multu_hi got %h exp 00000001", HI); end
        checks++; if (LO !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo got %h exp fffffffe", LO); end
        @(negedge clk);
    endtask

    task automatic test_div;
        int bc, ed;
        do_op(3'd2, 32'hFFFFFFF9, 32'h2, bc, ed); model(3'd2, 32'hFFFFFFF9, 32'h2);
        checks++; if (bc !== DC) begin errors++; $display("FAIL div_busy_cycles got %0d exp %0d", bc, DC); end
        checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", LO); end
        checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", HI); end
        do_op(3'd3, 32'h7, 32'h2, bc, ed); model(3'd3, 32'h7, 32'h2);
        checks++; if (LO !== 32'h3) begin errors++; $display("FAIL divu_lo got %h exp 00000003", LO); end
        checks++; if (HI !== 32'h1) begin errors++; $display("FAIL divu_hi got %h exp 00000001", HI); end
        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, bc, ed); model(3'd2, 32'h80000000, 32'hFFFFFFFF);
        checks++; if (LO !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h exp 80000000", LO); end
        checks++; if (HI !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h exp 00000000", HI); end
    endtask

    task automatic test_div_zero;
        int bc, ed;
        do_single(3'b100, 32'h12345678); model(3'b100, 32'h12345678, 32'h0);
        checks++; if (HI !== 32'h12345678) begin errors++; $display("FAIL mthi_hi got %h exp 12345678", HI); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_flags got busy=%b done=%b exp 0 0", busy, done); end
        do_single(3'b101, 32'h9ABCDEF0); model(3'b101, 32'h9ABCDEF0, 32'h0);
        checks++; if (LO !== 32'h9ABCDEF0) begin errors++; $display("FAIL mtlo_lo got %h exp 9abcdef0", LO); end
        do_op(3'd3, 32'h5, 32'h0, bc, ed); model(3'd3, 32'h5, 32'h0);
        checks++; if (bc !== DC) begin errors++; $display("FAIL divz_busy_cycles got %0d exp %0d", bc, DC); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL divz_done got %b exp 1", done); end
        checks++; if (HI !== 32'h12345678) begin errors++; $display("FAIL divz_hi got %h exp 12345678", HI); end
        checks++; if (LO !== 32'h9ABCDEF0) begin errors++; $display("FAIL divz_lo got %h exp 9abcdef0", LO); end
    endtask

    task automatic test_start_busy;
        int bc;
        start = 1'b1; op = 3'd0; A = 32'hFFFFFFFF; B = 32'h3;
        model(3'd0, 32'hFFFFFFFF, 32'h3);
        @(negedge clk);
        start = 1'b0; bc = int'(busy);
        @(negedge clk);
        bc += int'(busy); start = 1'b1; op = 3'b101; A = 32'hDEADBEEF;
        @(negedge clk);
        bc += int'(busy); op = 3'd2; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        while (busy && bc < 200) begin bc++; @(negedge clk); end
        checks++; if (bc !== MC) begin errors++; $display("FAIL sb_busy_cycles got %0d exp %0d", bc, MC); end
        checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL sb_hi got %h exp ffffffff", HI); end
        checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL sb_lo got %h exp fffffffd", LO); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sb_late_accept got busy=%b exp 0", busy); end
    endtask

    task automatic test_reset_mid;
        int seen;
        do_single(3'b100, 32'hA5A5A5A5);
        start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hi = 32'h0; exp_lo = 32'h0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
        checks++; if (HI !== 32'h0 || LO !== 32'h0) begin errors++; $display("FAIL rmid_hilo got %h %h exp 0 0", HI, LO); end
        seen = 0;
        repeat (20) begin if (done) seen++; @(negedge clk); end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_no_done got %0d pulses exp 0", seen); end
    endtask

    task automatic test_back_to_back;
        int bc, ed;
        do_op(3'd0, 32'd3, 32'd4, bc, ed); model(3'd0, 32'd3, 32'd4);
        checks++; if (LO !== 32'd12 || done !== 1'b1) begin errors++; $display("FAIL b2b_first got lo=%h done=%b exp 0000000c 1", LO, done); end
        do_op(3'd1, 32'd5, 32'd6, bc, ed); model(3'd1, 32'd5, 32'd6);
        checks++; if (bc !== MC) begin errors++; $display("FAIL b2b_busy_cycles got %0d exp %0d", bc, MC); end
        checks++; if (LO !== 32'd30 || HI !== 32'd0) begin errors++; $display("FAIL b2b_second got %h %h exp 00000000 0000001e", HI, LO); end
        @(negedge clk);
    endtask

    task automatic test_random;
        int bc, ed;
        logic [2:0] o;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'h0;
            if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            if (!o[2]) begin
                do_op(o, a, b, bc, ed); model(o, a, b);
                checks++; if (bc !== (o[1] ? DC : MC) || ed !== 0 || done !== 1'b1) begin errors++; $display("FAIL rnd_timing op=%0d got cycles=%0d early=%0d done=%b exp %0d 0 1", o, bc, ed, done, o[1] ? DC : MC); end
            end else begin
                do_single(o, a); model(o, a, b);
                checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rnd_single_flags op=%0d got busy=%b done=%b exp 0 0", o, busy, done); end
            end
            checks++; if (HI !== exp_hi || LO !== exp_lo) begin errors++; $display("FAIL rnd_hilo op=%0d a=%h b=%h got %h %h exp %h %h", o, a, b, HI, LO, exp_hi, exp_lo); end
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL rnd_done_drop got %b exp 0", done); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'h0; B = 32'h0;
        test_reset;
        test_mult;
        test_div;
        test_div_zero;
        test_start_busy;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
